multdiv_seq: RTL and testbench
==============================

# multdiv_seq

Iterative 32-bit signed multiply/divide sequencer for the processor's execute stage. Consumes the 7-bit cycle count from the shared `counter_64` step counter and drives that counter's clear. Runs one shift-add (multiply) or restoring (divide) iteration per cycle, then returns a result with exception flag and a one-cycle ready pulse to the pipeline stall logic.

## Interface
- WIDTH, 32, operand/result width; fixed at 32 for this revision.
- ITER, 32, iterations per operation; the completion count compare uses ITER-1.

- clk  input  1  single clock; all state updates on rising edge.
- clr  input  1  synchronous, active-low reset. One clock; reset is synchronous and active-low.
- ctrl_mult  input  1  start a signed multiply; sampled every edge.
- ctrl_div  input  1  start a signed divide; sampled every edge.
- data_a  input  32  multiplicand / dividend; latched on the start edge.
- data_b  input  32  multiplier / divisor; latched on the start edge.
- count  input  7  `q` output of the step counter.
- count_clr  output  1  drives the step counter's `clr`. High while the state is IDLE or DONE, or on any start.
- result  output  32  low 32 bits of the product, or the quotient.
- data_exception  output  1  overflow (multiply) or divide by zero; valid with data_resultRDY.
- data_resultRDY  output  1  one-cycle pulse; result and exception are valid in that cycle.

## Operation
- States: IDLE, RUN, DONE.
- IDLE, with ctrl_mult or ctrl_div high at an edge:
  - latch operands and op type;
  - go to RUN;
  - count reads 0 in the first RUN cycle.
- ctrl_mult and ctrl_div both high: multiply wins.
- RUN: one iteration per edge; the iteration at an edge uses the current count value.
  - When count == ITER-1 at an edge, perform the final iteration and go to DONE.
- DONE: data_resultRDY = 1 and result/data_exception are valid. Next edge goes to IDLE.
- A start in RUN or DONE aborts the current operation. The new operands are latched, the state goes to RUN, and the counter is cleared. No RDY pulse is issued for the aborted operation.
- Multiply:
  - operate on magnitudes with a 64-bit accumulator; negate if the operand signs differ;
  - result = product[31:0];
  - exception = 1 if product[63:31] is not all 0s or all 1s.
- Divide:
  - restoring division on magnitudes; quotient truncated toward zero;
  - quotient sign = XOR of the operand signs; remainder is discarded.
- Divide by zero (data_b == 0 latched):
  - exception = 1, result = 0;
  - full latency is still taken so the RDY timing is uniform.
- Divide 0x80000000 / 0xFFFFFFFF: result 0x80000000, exception = 1 (overflow).
- result register holds its last value until the next DONE. data_exception is 0 outside DONE.

## Timing
- Reset (clr = 0 at an edge):
  - state IDLE; result = 0, data_exception = 0, data_resultRDY = 0, count_clr = 1;
  - any operation in flight is dropped with no RDY pulse.
- Reset has priority over start at the same edge.
- Latency: start sampled at edge E0.
  - RUN covers the cycles after E0 through E32 (32 iterations at E1..E32).
  - DONE is the cycle after E32: data_resultRDY is high in the 33rd cycle after E0.
  - IDLE after E33.
- Back-to-back: a start sampled during DONE begins a new operation. The current RDY pulse is still seen that cycle because the outputs are registered.
- count_clr is combinational from state and the start inputs. The counter must therefore be 0 in the first RUN cycle.
- Count values of ITER or more in RUN are illegal. Force the state to DONE with exception = 1 as a safety net.

## Test plan
- Multiply 7 × -6 -> RDY pulse in the 33rd cycle after start; result 0xFFFFFFD6 (-42), exception 0.
- Multiply 0x00010000 × 0x00010000 -> result 0x00000000, exception 1.
- Divide -100 / 7 -> result 0xFFFFFFF2 (-14), exception 0. Divide 5 / 0 -> result 0, exception 1, same latency.
- Start multiply 3 × 4, then at count == 10 start divide 20 / 4 -> no RDY for the multiply; RDY in the 33rd cycle after the second start with result 5.
- Drive clr = 0 mid-RUN (count == 15) -> next cycle state IDLE, all outputs 0, count_clr = 1, no RDY pulse.
- ctrl_mult and ctrl_div both high with a = 9, b = 3 -> result 27 (multiply chosen). Then a start in the DONE cycle -> the RDY pulse is still seen and the second result follows 33 cycles later.

Source files
------------

// File: rtl/multdiv_seq.sv
// Iterative 32-bit signed multiply/divide sequencer: one shift-add or restoring
// divide step per clock, paced by the external step counter it clears.
module multdiv_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned ITER  = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             ctrl_mult,
  input  logic             ctrl_div,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  input  logic [6:0]       count,
  output logic             count_clr,
  output logic [WIDTH-1:0] result,
  output logic             data_exception,
  output logic             data_resultRDY
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                 r_state;
  state_t                 w_state_next;
  logic                   r_is_mult;
  logic                   r_neg;
  logic [WIDTH-1:0]       r_mcand;
  logic [2*WIDTH-1:0]     r_acc;
  logic [WIDTH-1:0]       r_result;
  logic                   r_exc;
  logic                   r_rdy;

  logic                   w_start;
  logic                   w_last;
  logic                   w_bad;
  logic [WIDTH-1:0]       w_a_mag;
  logic [WIDTH-1:0]       w_b_mag;
  logic [WIDTH:0]         w_msum;
  logic [2*WIDTH-1:0]     w_mul_next;
  logic [WIDTH:0]         w_rem_sh;
  logic                   w_ge;
  logic [WIDTH-1:0]       w_sub;
  logic [2*WIDTH-1:0]     w_div_next;
  logic [2*WIDTH-1:0]     w_acc_next;
  logic [2*WIDTH-1:0]     w_prod;
  logic                   w_mul_exc;
  logic [WIDTH-1:0]       w_qmag;
  logic [WIDTH-1:0]       w_quo;
  logic                   w_div_zero;
  logic                   w_div_ovf;
  logic [WIDTH-1:0]       w_fin_result;
  logic                   w_fin_exc;

  assign w_start = ctrl_mult | ctrl_div;
  assign w_last  = (count == 7'(ITER - 1));
  assign w_bad   = (count >= 7'(ITER));

  assign w_a_mag = data_a[WIDTH-1] ? WIDTH'(-data_a) : data_a;
  assign w_b_mag = data_b[WIDTH-1] ? WIDTH'(-data_b) : data_b;

  // Multiply step: conditionally add multiplicand to the high half, shift right.
  assign w_msum     = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                    + (r_acc[0] ? {1'b0, r_mcand} : (WIDTH+1)'(0));
  assign w_mul_next = {w_msum, r_acc[WIDTH-1:1]};

  // Divide step: shift remainder/quotient left, subtract divisor if it fits.
  assign w_rem_sh   = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_ge       = (w_rem_sh >= {1'b0, r_mcand});
  assign w_sub      = w_rem_sh[WIDTH-1:0] - r_mcand;
  assign w_div_next = {(w_ge ? w_sub : w_rem_sh[WIDTH-1:0]), r_acc[WIDTH-2:0], w_ge};

  assign w_acc_next = r_is_mult ? w_mul_next : w_div_next;

  assign w_prod     = r_neg ? (2*WIDTH)'(-w_acc_next) : w_acc_next;
  assign w_mul_exc  = ~(&w_prod[2*WIDTH-1:WIDTH-1]) & (|w_prod[2*WIDTH-1:WIDTH-1]);
  assign w_qmag     = w_acc_next[WIDTH-1:0];
  assign w_quo      = r_neg ? WIDTH'(-w_qmag) : w_qmag;
  assign w_div_zero = (r_mcand == '0);
  // A positive quotient with the top bit set only arises from MIN / -1.
  assign w_div_ovf  = ~r_neg & w_qmag[WIDTH-1];

  assign w_fin_result = r_is_mult ? w_prod[WIDTH-1:0] : (w_div_zero ? '0 : w_quo);
  assign w_fin_exc    = r_is_mult ? w_mul_exc : (w_div_zero | w_div_ovf);

  // State register.
  always_ff @(posedge clk) begin
    if (!clr) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and counter clear.
  always_comb begin
    w_state_next = r_state;
    count_clr    = (r_state != S_RUN) | w_start;
    case (r_state)
      S_IDLE: if (w_start) w_state_next = S_RUN;
      S_RUN: begin
        if (w_start)              w_state_next = S_RUN;
        else if (w_bad || w_last) w_state_next = S_DONE;
      end
      S_DONE:  w_state_next = w_start ? S_RUN : S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Operand latch, iteration datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (!clr) begin
      r_is_mult <= 1'b0;
      r_neg     <= 1'b0;
      r_mcand   <= '0;
      r_acc     <= '0;
      r_result  <= '0;
      r_exc     <= 1'b0;
      r_rdy     <= 1'b0;
    end else begin
      r_exc <= 1'b0;
      r_rdy <= 1'b0;
      if (w_start) begin
        r_is_mult <= ctrl_mult;
        r_neg     <= data_a[WIDTH-1] ^ data_b[WIDTH-1];
        r_mcand   <= ctrl_mult ? w_a_mag : w_b_mag;
        r_acc     <= {WIDTH'(0), (ctrl_mult ? w_b_mag : w_a_mag)};
      end else if (r_state == S_RUN) begin
        if (w_bad) begin
          r_result <= '0;
          r_exc    <= 1'b1;
          r_rdy    <= 1'b1;
        end else begin
          r_acc <= w_acc_next;
          if (w_last) begin
            r_result <= w_fin_result;
            r_exc    <= w_fin_exc;
            r_rdy    <= 1'b1;
          end
        end
      end
    end
  end

  assign result         = r_result;
  assign data_exception = r_exc;
  assign data_resultRDY = r_rdy;

endmodule

// File: tb/tb_multdiv_seq.sv
// Bench for multdiv_seq: models the step counter, predicts every cycle's outputs
// from plain signed arithmetic plus start/age bookkeeping, and runs directed and random ops.
module tb_multdiv_seq;

  logic        clk = 1'b0;
  logic        clr;
  logic        ctrl_mult;
  logic        ctrl_div;
  logic [31:0] data_a;
  logic [31:0] data_b;
  logic [6:0]  count;
  logic        count_clr;
  logic [31:0] result;
  logic        data_exception;
  logic        data_resultRDY;

  logic [6:0]  cnt = 7'd0;
  logic        force_bad;
  logic        chk_en = 1'b0;

  int checks = 0;
  int errors = 0;

  // Model state: in-flight op age (1 = first RUN cycle, 33 = RDY cycle).
  logic        m_valid = 1'b0;
  int          m_age   = 0;
  logic [31:0] m_res   = '0;
  logic        m_exc   = 1'b0;
  logic        m_res_known  = 1'b1;
  logic [31:0] m_last       = '0;
  logic        m_last_known = 1'b1;

  multdiv_seq dut (
    .clk            (clk),
    .clr            (clr),
    .ctrl_mult      (ctrl_mult),
    .ctrl_div       (ctrl_div),
    .data_a         (data_a),
    .data_b         (data_b),
    .count          (count),
    .count_clr      (count_clr),
    .result         (result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY)
  );

  always #5 clk = ~clk;

  // Shared step counter; force_bad injects an illegal count value.
  always @(posedge clk) cnt <= count_clr ? 7'd0 : cnt + 7'd1;
  assign count = force_bad ? 7'd100 : cnt;

  function automatic logic [32:0] ref_op(input logic is_mult, input logic [31:0] a,
                                         input logic [31:0] b);
    longint sa, sb, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (is_mult) begin
      p = sa * sb;
      return {(p != longint'($signed(p[31:0]))), p[31:0]};
    end
    if (b == 32'd0) return {1'b1, 32'h0};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b1, 32'h8000_0000};
    p = sa / sb;
    return {1'b0, p[31:0]};
  endfunction

  always @(posedge clk) begin
    if (!clr) begin
      m_valid      <= 1'b0;
      m_age        <= 0;
      m_last       <= '0;
      m_last_known <= 1'b1;
    end else if (ctrl_mult || ctrl_div) begin
      m_valid          <= 1'b1;
      m_age            <= 1;
      {m_exc, m_res}   <= ref_op(ctrl_mult, data_a, data_b);
      m_res_known      <= 1'b1;
    end else if (m_valid) begin
      if (m_age == 33) begin
        m_valid <= 1'b0;
      end else if (force_bad) begin
        m_age        <= 33;
        m_exc        <= 1'b1;
        m_res_known  <= 1'b0;
        m_last_known <= 1'b0;
      end else begin
        m_age <= m_age + 1;
        if (m_age == 32) begin
          m_last       <= m_res;
          m_last_known <= 1'b1;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    logic rdy_e;
    logic run_e;
    if (chk_en) begin
      rdy_e = m_valid && (m_age == 33);
      run_e = m_valid && (m_age <= 32);
      chk("cyc rdy", 32'(data_resultRDY), 32'(rdy_e));
      chk("cyc exc", 32'(data_exception), rdy_e ? 32'(m_exc) : 32'd0);
      if (rdy_e ? m_res_known : m_last_known)
        chk("cyc result", result, rdy_e ? m_res : m_last);
      chk("cyc count_clr", 32'(count_clr), 32'(!run_e || ctrl_mult || ctrl_div));
    end
  end

  // Called at posedge+1; start is sampled at the next edge, returns at that edge+1.
  task automatic start_op(input logic m, input logic d, input logic [31:0] a,
                          input logic [31:0] b);
    ctrl_mult = m;
    ctrl_div  = d;
    data_a    = a;
    data_b    = b;
    @(posedge clk); #1;
    ctrl_mult = 1'b0;
    ctrl_div  = 1'b0;
    data_a    = $urandom();
    data_b    = $urandom();
  endtask

  task automatic wait_rdy(input string name, input logic do_chk, input logic [31:0] er,
                          input logic ee);
    int n;
    n = 1;
    while (!data_resultRDY && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk({name, " latency"}, 32'(n), 32'd33);
    if (do_chk) begin
      chk({name, " result"}, result, er);
      chk({name, " exc"}, 32'(data_exception), 32'(ee));
    end
  endtask

  task automatic wait_count(input logic [6:0] v);
    int n;
    n = 0;
    while (count != v && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("count reach", 32'(count), 32'(v));
  endtask

  task automatic idle(input int k);
    repeat (k) begin
      @(posedge clk); #1;
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0, 1, 2: return $urandom();
      3:       return 32'($urandom_range(0, 100)) - 32'd50;
      4:       return 32'd0;
      5:       return 32'h8000_0000;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  initial begin
    logic        seen;
    logic [32:0] e;
    logic [31:0] a, b;
    int          op;
    clr = 1'b0; ctrl_mult = 1'b0; ctrl_div = 1'b0; force_bad = 1'b0;
    data_a = '0; data_b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_en = 1'b1;
    chk("reset rdy", 32'(data_resultRDY), 32'd0);
    chk("reset result", result, 32'd0);
    chk("reset exc", 32'(data_exception), 32'd0);
    chk("reset count_clr", 32'(count_clr), 32'd1);
    clr = 1'b1;
    idle(2);

    start_op(1, 0, 32'd7, 32'hFFFF_FFFA);
    wait_rdy("mul 7x-6", 1, 32'hFFFF_FFD6, 1'b0);
    idle(2);
    start_op(1, 0, 32'h0001_0000, 32'h0001_0000);
    wait_rdy("mul ovf", 1, 32'h0, 1'b1);
    idle(1);
    start_op(0, 1, 32'hFFFF_FF9C, 32'd7);
    wait_rdy("div -100/7", 1, 32'hFFFF_FFF2, 1'b0);
    idle(1);
    start_op(0, 1, 32'd5, 32'd0);
    wait_rdy("div by 0", 1, 32'h0, 1'b1);
    idle(1);
    start_op(0, 1, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_rdy("div min/-1", 1, 32'h8000_0000, 1'b1);
    idle(1);

    // Abort a multiply with a divide at count 10.
    start_op(1, 0, 32'd3, 32'd4);
    wait_count(7'd10);
    start_op(0, 1, 32'd20, 32'd4);
    wait_rdy("abort div", 1, 32'd5, 1'b0);
    idle(2);

    // Reset mid-RUN.
    start_op(1, 0, 32'd11, 32'd13);
    wait_count(7'd15);
    clr = 1'b0;
    @(posedge clk); #1;
    clr = 1'b1;
    chk("midrst rdy", 32'(data_resultRDY), 32'd0);
    chk("midrst result", result, 32'd0);
    chk("midrst exc", 32'(data_exception), 32'd0);
    chk("midrst count_clr", 32'(count_clr), 32'd1);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      seen |= data_resultRDY;
    end
    chk("midrst no rdy", 32'(seen), 32'd0);

    // Both starts high, then a start during DONE.
    start_op(1, 1, 32'd9, 32'd3);
    wait_rdy("both high", 1, 32'd27, 1'b0);
    start_op(1, 0, 32'hFFFF_FFFB, 32'd4);
    wait_rdy("chained", 1, 32'hFFFF_FFEC, 1'b0);
    idle(2);

    // Illegal count in RUN forces DONE with exception.
    start_op(1, 0, 32'd3, 32'd4);
    wait_count(7'd5);
    force_bad = 1'b1;
    @(posedge clk); #1;
    force_bad = 1'b0;
    chk("bad count rdy", 32'(data_resultRDY), 32'd1);
    chk("bad count exc", 32'(data_exception), 32'd1);
    idle(2);

    for (int i = 0; i < 40; i++) begin
      a  = pick();
      b  = pick();
      op = int'($urandom_range(0, 2));
      start_op(op != 1, op != 0, a, b);
      if ($urandom_range(0, 3) == 0) begin
        idle(int'($urandom_range(1, 30)));
      end else begin
        e = ref_op(op != 1, a, b);
        wait_rdy("rand", 1, e[31:0], e[32]);
      end
      idle(int'($urandom_range(0, 2)));
    end
    idle(40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
